// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
// Game-state engine feeding the LED display block. Physics advance only on
// the one-cycle game-rate enable (tick); the flap button edge is detected
// here on clk.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   tick       game-rate enable, one clk wide
//   flap       player button level, already synchronized to clk
//   BirdY      bird row (0 = top)
//   PipeX      pipe column
//   GapY       first row of the pipe gap
//   GameState  00 IDLE, 01 PLAY, 11 GAME_OVER (10 never driven)
//   BlinkOn    bird visibility enable
//   Score      pipes cleared, saturating at 255
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a flap to start; positions parked at reset values
// ST_PLAY   | game running; gravity, flap and pipe scroll on each tick
// ST_OVER   | collision seen; positions frozen, bird blinks until a flap
// ST_BAD    | unreachable encoding; recovers to ST_IDLE on the next clk

module flappy_game_ctrl #(
  parameter int unsigned BIRD_X      = 12,
  parameter int unsigned GAP_SIZE    = 4,
  parameter int unsigned PIPE_DIV    = 2,
  parameter int unsigned FLAP_UP     = 2,
  parameter int unsigned BLINK_TICKS = 4,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       flap,
  output logic [3:0] BirdY,
  output logic [3:0] PipeX,
  output logic [3:0] GapY,
  output logic [1:0] GameState,
  output logic       BlinkOn,
  output logic [7:0] Score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_BAD  = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  localparam logic [3:0] BIRD_HOME  = 4'd8;
  localparam logic [3:0] GAP_HOME   = 4'd6;
  localparam logic [3:0] BIRD_X4    = 4'(BIRD_X);
  localparam logic [3:0] FLAP_UP4   = 4'(FLAP_UP);
  localparam logic [4:0] GAP5       = 5'(GAP_SIZE);
  localparam logic [4:0] GAP_LIMIT  = 5'(16 - GAP_SIZE);
  localparam logic [7:0] PIPE_LAST  = 8'(PIPE_DIV - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] birdy_q, birdy_d;
  logic [3:0] pipex_q, pipex_d;
  logic [3:0] gapy_q, gapy_d;
  logic       blink_on_q, blink_on_d;
  logic [7:0] score_q, score_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] pipe_cnt_q, pipe_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       flap_pending_q, flap_pending_d;
  logic       flap_q, flap_q_d;

  logic       flap_rise;
  logic       lfsr_fb;
  logic [3:0] new_gap;
  logic       flap_now;
  logic       ground_hit;
  logic       pipe_step;
  logic       hit;
  logic [4:0] gap_end;

  assign flap_rise = flap & ~flap_q;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting left.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Fold the top of the nibble back so the whole gap stays on screen.
  always_comb begin
    new_gap = lfsr_q[3:0];
    if ({1'b0, lfsr_q[3:0]} > GAP_LIMIT) new_gap = lfsr_q[3:0] - GAP5[3:0];
  end

  always_comb begin
    state_d        = state_q;
    birdy_d        = birdy_q;
    pipex_d        = pipex_q;
    gapy_d         = gapy_q;
    blink_on_d     = blink_on_q;
    score_d        = score_q;
    pipe_cnt_d     = pipe_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    flap_pending_d = flap_pending_q;
    flap_q_d       = flap;
    lfsr_d         = {lfsr_q[6:0], lfsr_fb};
    flap_now       = 1'b0;
    ground_hit     = 1'b0;
    pipe_step      = 1'b0;
    hit            = 1'b0;
    gap_end        = 5'd0;

    case (state_q)
      ST_IDLE: begin
        birdy_d        = BIRD_HOME;
        pipex_d        = 4'd0;
        blink_on_d     = 1'b1;
        flap_pending_d = 1'b0;
        if (flap_rise) begin
          state_d     = ST_PLAY;
          score_d     = 8'd0;
          gapy_d      = new_gap;
          pipe_cnt_d  = 8'd0;
          blink_cnt_d = 8'd0;
        end
      end

      ST_PLAY: begin
        blink_on_d = 1'b1;
        if (tick) begin
          // A rise landing on the tick cycle counts for this tick.
          flap_now = flap_pending_q | flap_rise;
          if (flap_now) begin
            birdy_d = (birdy_q >= FLAP_UP4) ? (birdy_q - FLAP_UP4) : 4'd0;
          end else if (birdy_q == 4'd15) begin
            ground_hit = 1'b1;
          end else begin
            birdy_d = birdy_q + 4'd1;
          end

          if (pipe_cnt_q == PIPE_LAST) begin
            pipe_cnt_d = 8'd0;
            pipe_step  = 1'b1;
            pipex_d    = pipex_q + 4'd1;
            if (pipex_q == 4'd15) gapy_d = new_gap;
          end else begin
            pipe_cnt_d = pipe_cnt_q + 8'd1;
          end

          // Collision uses the post-update positions; 5 bits so a gap
          // ending at row 16 does not wrap.
          gap_end = {1'b0, gapy_d} + GAP5;
          hit = ground_hit |
                ((pipex_d == BIRD_X4) &
                 (({1'b0, birdy_d} < {1'b0, gapy_d}) | ({1'b0, birdy_d} >= gap_end)));

          if (pipe_step && (pipex_q == BIRD_X4) && !hit && (score_q != 8'hFF))
            score_d = score_q + 8'd1;

          flap_pending_d = 1'b0;
          if (hit) begin
            state_d     = ST_OVER;
            blink_on_d  = 1'b0;
            blink_cnt_d = 8'd0;
          end
        end else if (flap_rise) begin
          flap_pending_d = 1'b1;
        end
      end

      ST_OVER: begin
        flap_pending_d = 1'b0;
        if (flap_rise) begin
          // Score is deliberately kept for display until the next start.
          state_d     = ST_IDLE;
          birdy_d     = BIRD_HOME;
          pipex_d     = 4'd0;
          gapy_d      = GAP_HOME;
          blink_on_d  = 1'b1;
          pipe_cnt_d  = 8'd0;
          blink_cnt_d = 8'd0;
        end else if (tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = 8'd0;
            blink_on_d  = ~blink_on_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d        = ST_IDLE;
        birdy_d        = BIRD_HOME;
        pipex_d        = 4'd0;
        gapy_d         = GAP_HOME;
        blink_on_d     = 1'b1;
        pipe_cnt_d     = 8'd0;
        blink_cnt_d    = 8'd0;
        flap_pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      birdy_q        <= BIRD_HOME;
      pipex_q        <= 4'd0;
      gapy_q         <= GAP_HOME;
      blink_on_q     <= 1'b1;
      score_q        <= 8'd0;
      lfsr_q         <= LFSR_SEED;
      pipe_cnt_q     <= 8'd0;
      blink_cnt_q    <= 8'd0;
      flap_pending_q <= 1'b0;
      flap_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      birdy_q        <= birdy_d;
      pipex_q        <= pipex_d;
      gapy_q         <= gapy_d;
      blink_on_q     <= blink_on_d;
      score_q        <= score_d;
      lfsr_q         <= lfsr_d;
      pipe_cnt_q     <= pipe_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      flap_pending_q <= flap_pending_d;
      flap_q         <= flap_q_d;
    end
  end

  assign BirdY     = birdy_q;
  assign PipeX     = pipex_q;
  assign GapY      = gapy_q;
  assign GameState = state_q;
  assign BlinkOn   = blink_on_q;
  assign Score     = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl
// Directed scenarios followed by randomized games, every cycle compared
// against a behavioural model of the game rules.
// Ports of the DUT are driven/observed through same-named tb signals.

module tb_flappy_game_ctrl;

  localparam int PIPE_DIV    = 2;
  localparam int BLINK_TICKS = 4;
  localparam int GAP_SIZE    = 4;
  localparam int BIRD_X      = 12;

  logic       clk;
  logic       reset_n;
  logic       tick;
  logic       flap;
  logic [3:0] BirdY;
  logic [3:0] PipeX;
  logic [3:0] GapY;
  logic [1:0] GameState;
  logic       BlinkOn;
  logic [7:0] Score;

  flappy_game_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .flap      (flap),
    .BirdY     (BirdY),
    .PipeX     (PipeX),
    .GapY      (GapY),
    .GameState (GameState),
    .BlinkOn   (BlinkOn),
    .Score     (Score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 play, 3 game over.
  int         m_st, m_bird, m_px, m_gap, m_score, m_ticks, m_over_ticks;
  bit         m_blink, m_pend, m_fprev;
  logic [7:0] m_lfsr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_bird = 8; m_px = 0; m_gap = 6; m_score = 0;
    m_ticks = 0; m_over_ticks = 0; m_blink = 1; m_pend = 0; m_fprev = 0;
    m_lfsr = 8'hA5;
  endtask

  task automatic model_step(input bit t, input bit f);
    bit rise, ground, stepped, hit;
    int g, newgap, oldpx;
    rise = f && !m_fprev;
    g = int'(m_lfsr[3:0]);
    newgap = (g > 16 - GAP_SIZE) ? g - GAP_SIZE : g;
    if (m_st == 0) begin
      if (rise) begin
        m_st = 1; m_score = 0; m_px = 0; m_gap = newgap; m_bird = 8;
        m_ticks = 0; m_pend = 0;
      end
    end else if (m_st == 1) begin
      if (t) begin
        ground = 0;
        if (m_pend || rise) m_bird = (m_bird - 2 < 0) ? 0 : m_bird - 2;
        else if (m_bird == 15) ground = 1;
        else m_bird = m_bird + 1;
        m_ticks++;
        stepped = (m_ticks % PIPE_DIV) == 0;
        oldpx = m_px;
        if (stepped) begin
          m_px = (m_px + 1) % 16;
          if (m_px == 0) m_gap = newgap;
        end
        hit = ground || (m_px == BIRD_X && (m_bird < m_gap || m_bird >= m_gap + GAP_SIZE));
        if (stepped && oldpx == BIRD_X && !hit) m_score = (m_score >= 255) ? 255 : m_score + 1;
        if (hit) begin
          m_st = 3; m_blink = 0; m_over_ticks = 0;
        end
        m_pend = 0;
      end else if (rise) begin
        m_pend = 1;
      end
    end else begin
      if (rise) begin
        m_st = 0; m_bird = 8; m_px = 0; m_gap = 6; m_blink = 1;
      end else if (t) begin
        m_over_ticks++;
        if (m_over_ticks % BLINK_TICKS == 0) m_blink = !m_blink;
      end
    end
    m_fprev = f;
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  task automatic compare_all();
    chk("BirdY", BirdY, m_bird);
    chk("PipeX", PipeX, m_px);
    chk("GapY", GapY, m_gap);
    chk("GameState", GameState, m_st);
    chk("BlinkOn", BlinkOn, m_blink);
    chk("Score", Score, m_score);
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit t, input bit f);
    tick = t;
    flap = f;
    model_step(t, f);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Flap pulse followed by a tick, so the flap lands via the pending flag.
  task automatic flap_tick(input bit f);
    cyc(1'b0, f);
    cyc(1'b1, 1'b0);
  endtask

  initial begin
    int n;
    bit f;
    tick = 1'b0;
    flap = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #11;
    chk("rst_BirdY", BirdY, 8);
    chk("rst_PipeX", PipeX, 0);
    chk("rst_GapY", GapY, 6);
    chk("rst_GameState", GameState, 0);
    chk("rst_BlinkOn", BlinkOn, 1);
    chk("rst_Score", Score, 0);
    #1 reset_n = 1'b1;

    // Start, play a few ticks, then pull reset between clock edges.
    cyc(1'b0, 1'b1);
    chk("start_state", GameState, 1);
    chk("start_gap_range", GapY <= 4'd12, 1);
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    chk("play_bird_before_rst", BirdY, 11);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_BirdY", BirdY, 8);
    chk("async_PipeX", PipeX, 0);
    chk("async_GapY", GapY, 6);
    chk("async_GameState", GameState, 0);
    chk("async_BlinkOn", BlinkOn, 1);
    chk("async_Score", Score, 0);
    #1 reset_n = 1'b1;

    // Gravity to the floor, then the floor hit ends the game.
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    repeat (7) cyc(1'b1, 1'b0);
    chk("gravity_floor", BirdY, 15);
    chk("gravity_alive", GameState, 1);
    cyc(1'b1, 1'b0);
    chk("ground_over", GameState, 3);
    chk("ground_bird", BirdY, 15);
    chk("ground_blink", BlinkOn, 0);

    // Blink toggles every 4 ticks.
    repeat (3) cyc(1'b1, 1'b0);
    chk("blink_t3", BlinkOn, 0);
    cyc(1'b1, 1'b0);
    chk("blink_t4", BlinkOn, 1);
    repeat (4) cyc(1'b1, 1'b0);
    chk("blink_t8", BlinkOn, 0);
    chk("over_frozen_px", PipeX, 4);

    // Restart to idle; ticks are ignored there.
    cyc(1'b0, 1'b1);
    chk("restart_idle", GameState, 0);
    chk("restart_bird", BirdY, 8);
    chk("restart_px", PipeX, 0);
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    chk("idle_tick_ignored", BirdY, 8);

    // Ceiling and flap coalescing.
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("double_flap_single", BirdY, 6);
    repeat (3) flap_tick(1'b1);
    chk("flap_to_top", BirdY, 0);
    cyc(1'b1, 1'b0);
    chk("fall_to_1", BirdY, 1);
    cyc(1'b1, 1'b1);
    chk("flap_same_tick", BirdY, 0);
    cyc(1'b0, 1'b0);
    flap_tick(1'b1);
    chk("ceiling_sat", BirdY, 0);
    chk("ceiling_alive", GameState, 1);

    // Steer through the gap until the first pipe is cleared.
    for (int i = 0; i < 100 && m_score == 0; i++) flap_tick(m_bird >= m_gap + 2);
    chk("score_after_pass", Score, 1);
    chk("score_alive", GameState, 1);

    // Next lap: keep steering until column 9, then leave the gap.
    for (int i = 0; i < 100 && m_px != 9; i++) flap_tick(m_bird >= m_gap + 2);
    f = (m_gap >= 1);
    for (int i = 0; i < 40 && m_st == 1; i++) flap_tick(f);
    chk("pipe_hit_over", GameState, 3);
    chk("pipe_hit_px", PipeX, BIRD_X);
    chk("pipe_hit_score", Score, 1);

    // Score held through idle, cleared on the next start.
    cyc(1'b0, 1'b1);
    chk("held_state", GameState, 0);
    chk("held_score", Score, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("new_game_score", Score, 0);
    chk("new_game_state", GameState, 1);
    for (int i = 0; i < 60 && m_st == 1; i++) cyc(1'b1, 1'b0);
    chk("new_game_over", GameState, 3);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    // Randomized games.
    for (int gi = 0; gi < 150; gi++) begin
      n = $urandom_range(0, 5);
      repeat (n) cyc(1'($urandom_range(0, 1)), 1'b0);
      cyc(1'($urandom_range(0, 1)), 1'b1);
      chk("rand_start", GameState, 1);
      chk("rand_gap_range", GapY <= 4'd12, 1);
      for (int k = 0; k < 80 && m_st == 1; k++)
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
      for (int k = 0; k < 60 && m_st == 1; k++) cyc(1'b1, 1'b0);
      chk("rand_over", GameState, 3);
      n = $urandom_range(0, 9);
      repeat (n) cyc(1'($urandom_range(0, 1)), 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      chk("rand_back_idle", GameState, 0);
      cyc(1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
